// File: rtl/scan_chain_checker.sv
// On-chip scan-shift tester: drives NUM_CHAINS chains with a selectable pattern and checks
// each chain output against the expected bit delayed by L. Optional: SCAN_CHK_FAIL_CAPTURE_EN.
module scan_chain_checker #(
  parameter int CHAIN_LEN  = 1972,
  parameter int NUM_CHAINS = 1,
  parameter int PAT_W      = 5,
  parameter int LAT_ADJ    = 0,
  parameter int ERR_W      = 16
) (
  input  logic                  clk,
  input  logic                  rstp,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [PAT_W-1:0]      pattern,
  output logic                  test_mode,
  output logic                  scan_enable,
  output logic [NUM_CHAINS-1:0] scan_data_in,
  input  logic [NUM_CHAINS-1:0] scan_data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [NUM_CHAINS-1:0] err_chain
`ifdef SCAN_CHK_FAIL_CAPTURE_EN
  ,
  output logic [$clog2(CHAIN_LEN)-1:0]                         first_fail_idx,
  output logic [(NUM_CHAINS > 1 ? $clog2(NUM_CHAINS) : 1)-1:0] first_fail_chain,
  output logic                                                 first_fail_vld
`endif
);

  localparam int L    = CHAIN_LEN + LAT_ADJ;
  localparam int NMAX = (PAT_W > CHAIN_LEN) ? PAT_W : CHAIN_LEN;
  localparam int CW   = $clog2(L + NMAX);

  localparam logic [CW-1:0] L_C       = CW'(L);
  localparam logic [CW-1:0] LAST_FULL = CW'(L + CHAIN_LEN - 1);
  localparam logic [CW-1:0] LAST_USER = CW'(L + PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {
    MODE_ALT  = 2'b00,
    MODE_USER = 2'b01,
    MODE_ZERO = 2'b10,
    MODE_ONE  = 2'b11
  } scan_mode_e;

  // Odd chains carry the inverted stream so chain-to-chain shorts show up as mismatches.
  function automatic logic [NUM_CHAINS-1:0] odd_mask();
    logic [NUM_CHAINS-1:0] m;
    for (int k = 0; k < NUM_CHAINS; k++) m[k] = k[0];
    return m;
  endfunction

  localparam logic [NUM_CHAINS-1:0] ODD_MASK = odd_mask();

  function automatic logic base_bit(scan_mode_e m, logic [PAT_W-1:0] p, logic [CW-1:0] i);
    logic b;
    b = 1'b0;
    case (m)
      MODE_ALT:  b = i[0];
      MODE_USER: begin
        b = p[PAT_W-1];
        for (int j = 0; j < PAT_W - 1; j++) if (i == CW'(j)) b = p[j];
      end
      MODE_ZERO: b = 1'b0;
      MODE_ONE:  b = 1'b1;
      default:   b = 1'b0;
    endcase
    return b;
  endfunction

  state_e                  state;
  scan_mode_e              mode_q;
  logic [PAT_W-1:0]        pat_q;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_nxt;
  logic [CW-1:0]           last_c;
  logic [NUM_CHAINS-1:0]   sdi_nxt;
  logic [NUM_CHAINS-1:0]   exp_vec;
  logic [NUM_CHAINS-1:0]   mism;
  logic [ERR_W:0]          mism_cnt;
  logic [ERR_W:0]          err_sum;
  logic [ERR_W-1:0]        err_nxt;
`ifdef SCAN_CHK_FAIL_CAPTURE_EN
  logic [(NUM_CHAINS > 1 ? $clog2(NUM_CHAINS) : 1)-1:0] low_chain;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    cnt_nxt  = cnt + 1'b1;
    last_c   = (mode_q == MODE_USER) ? LAST_USER : LAST_FULL;
    sdi_nxt  = {NUM_CHAINS{base_bit(mode_q, pat_q, cnt_nxt)}} ^ ODD_MASK;
    exp_vec  = {NUM_CHAINS{base_bit(mode_q, pat_q, cnt - L_C)}} ^ ODD_MASK;
    mism     = '0;
    mism_cnt = '0;
    for (int k = 0; k < NUM_CHAINS; k++) begin
      // Written as if/else so an X or Z on the chain output falls into the mismatch branch.
      if (scan_data_out[k] == exp_vec[k]) mism[k] = 1'b0;
      else                                mism[k] = (cnt >= L_C);
      mism_cnt = mism_cnt + {{ERR_W{1'b0}}, mism[k]};
    end
    err_sum = {1'b0, err_count} + mism_cnt;
    err_nxt = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
`ifdef SCAN_CHK_FAIL_CAPTURE_EN
    low_chain = '0;
    for (int k = NUM_CHAINS - 1; k >= 0; k--) if (mism[k]) low_chain = $bits(low_chain)'(k);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rstp) begin
      state        <= IDLE;
      mode_q       <= MODE_ALT;
      pat_q        <= '0;
      cnt          <= '0;
      test_mode    <= 1'b0;
      scan_enable  <= 1'b0;
      scan_data_in <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      err_chain    <= '0;
`ifdef SCAN_CHK_FAIL_CAPTURE_EN
      first_fail_idx   <= '0;
      first_fail_chain <= '0;
      first_fail_vld   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q       <= scan_mode_e'(mode);
            pat_q        <= pattern;
            cnt          <= '0;
            err_count    <= '0;
            err_chain    <= '0;
            pass         <= 1'b0;
            test_mode    <= 1'b1;
            scan_enable  <= 1'b1;
            busy         <= 1'b1;
            scan_data_in <= {NUM_CHAINS{base_bit(scan_mode_e'(mode), pattern, '0)}} ^ ODD_MASK;
            state        <= SHIFT;
`ifdef SCAN_CHK_FAIL_CAPTURE_EN
            first_fail_idx   <= '0;
            first_fail_chain <= '0;
            first_fail_vld   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          err_count <= err_nxt;
          err_chain <= err_chain | mism;
`ifdef SCAN_CHK_FAIL_CAPTURE_EN
          if (!first_fail_vld && (|mism)) begin
            first_fail_vld   <= 1'b1;
            first_fail_idx   <= $bits(first_fail_idx)'(cnt - L_C);
            first_fail_chain <= low_chain;
          end
`endif
          if (cnt == last_c) begin
            state        <= DONE;
            busy         <= 1'b0;
            scan_enable  <= 1'b0;
            test_mode    <= 1'b0;
            scan_data_in <= '0;
            done         <= 1'b1;
            pass         <= (err_nxt == '0);
          end else begin
            cnt          <= cnt_nxt;
            scan_data_in <= sdi_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_checker.sv
// Randomized self-checking bench for scan_chain_checker with two behavioural 8/9-flop chains
// and a run-level reference model built from the pattern rules.
module tb_scan_chain_checker;

  localparam int CL = 8;
  localparam int NC = 2;
  localparam int PW = 5;
  localparam int LL = CL;

  logic          clk = 1'b0;
  logic          rstp;
  logic          start;
  logic [1:0]    mode;
  logic [PW-1:0] pattern;
  logic          test_mode;
  logic          scan_enable;
  logic [NC-1:0] scan_data_in;
  logic [NC-1:0] scan_data_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [NC-1:0] err_chain;
`ifdef SCAN_CHK_FAIL_CAPTURE_EN
  logic [2:0]    ff_idx;
  logic [0:0]    ff_chain;
  logic          ff_vld;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  scan_chain_checker #(
    .CHAIN_LEN(CL), .NUM_CHAINS(NC), .PAT_W(PW), .LAT_ADJ(0), .ERR_W(16)
  ) dut (
    .clk(clk), .rstp(rstp), .start(start), .mode(mode), .pattern(pattern),
    .test_mode(test_mode), .scan_enable(scan_enable), .scan_data_in(scan_data_in),
    .scan_data_out(scan_data_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .err_chain(err_chain)
`ifdef SCAN_CHK_FAIL_CAPTURE_EN
    , .first_fail_idx(ff_idx), .first_fail_chain(ff_chain), .first_fail_vld(ff_vld)
`endif
  );

  // Behavioural chains: up to 9 flops, output tapped at flop clen-1, with fault injection.
  logic [8:0] chain     [NC];
  logic [8:0] preset    [NC];
  logic [3:0] clen      [NC];
  logic       stuck_en  [NC];
  logic       stuck_val [NC];
  logic       x_en      [NC];
  logic       load;

  always @(posedge clk)
    for (int k = 0; k < NC; k++)
      if (load)             chain[k] <= preset[k];
      else if (scan_enable) chain[k] <= {chain[k][7:0], scan_data_in[k]};

  always_comb begin
    scan_data_out = '0;
    for (int k = 0; k < NC; k++)
      scan_data_out[k] = x_en[k] ? 1'bx : (stuck_en[k] ? stuck_val[k] : chain[k][clen[k] - 4'd1]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic bref(input int m, input logic [PW-1:0] p, input int i);
    case (m)
      0:       return logic'(i % 2);
      1:       return p[(i < PW) ? i : PW - 1];
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic setup(input logic [8:0] p0, input logic [8:0] p1, input int l0, input int l1,
                       input logic se0, input logic sv0, input logic se1, input logic sv1);
    preset[0] = p0;  preset[1] = p1;
    clen[0] = 4'(l0); clen[1] = 4'(l1);
    stuck_en[0] = se0; stuck_val[0] = sv0;
    stuck_en[1] = se1; stuck_val[1] = sv1;
    x_en[0] = 1'b0; x_en[1] = 1'b0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Launches one run, checks it against the model, returns the DUT's final error results.
  task automatic run(input int m, input logic [PW-1:0] p, input int mid_start,
                     output logic [31:0] got_err, output logic [31:0] got_mask);
    int n, exp_len, exp_err, cyc, ffi, ffc;
    logic [NC-1:0] exp_mask;
    logic ffv, o, e, b;
    n = (m == 1) ? PW : CL;
    exp_len = LL + n;
    exp_err = 0; exp_mask = '0; ffv = 1'b0; ffi = 0; ffc = 0;
    for (int c = LL; c < LL + n; c++)
      for (int k = 0; k < NC; k++) begin
        e = bref(m, p, c - LL) ^ logic'(k % 2);
        if (stuck_en[k])              o = stuck_val[k];
        else if (c >= int'(clen[k]))  o = bref(m, p, c - int'(clen[k])) ^ logic'(k % 2);
        else                          o = preset[k][int'(clen[k]) - 1 - c];
        if (x_en[k] || o != e) begin
          exp_err++;
          exp_mask[k] = 1'b1;
          if (!ffv) begin ffv = 1'b1; ffi = c - LL; ffc = k; end
        end
      end

    mode = 2'(m); pattern = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      start = (cyc == mid_start);
      if (cyc < exp_len) begin
        b = bref(m, p, cyc);
        check("sdi", 32'(scan_data_in), 32'({~b, b}));
        check("tm_se", 32'({test_mode, scan_enable}), 32'b11);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("run_len", 32'(cyc), 32'(exp_len));
    check("done", 32'(done), 32'd1);
    check("busy_done", 32'({busy, test_mode, scan_enable}), 32'd0);
    check("pass", 32'(pass), 32'(exp_err == 0));
    check("err_count", 32'(err_count), 32'(exp_err));
    check("err_chain", 32'(err_chain), 32'(exp_mask));
`ifdef SCAN_CHK_FAIL_CAPTURE_EN
    check("ff_vld", 32'(ff_vld), 32'(ffv));
    if (ffv) begin
      check("ff_idx", 32'(ff_idx), 32'(ffi));
      check("ff_chain", 32'(ff_chain), 32'(ffc));
    end
`endif
    got_err  = 32'(err_count);
    got_mask = 32'(err_chain);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("pass_hold", 32'(pass), 32'(exp_err == 0));
    check("err_hold", 32'(err_count), 32'(exp_err));
  endtask

  logic [31:0] r_err, r_mask;

  initial begin
    rstp = 1'b1; start = 1'b0; mode = '0; pattern = '0; load = 1'b0;
    for (int k = 0; k < NC; k++) begin
      preset[k] = '0; clen[k] = 4'd8; stuck_en[k] = 1'b0; stuck_val[k] = 1'b0; x_en[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'({test_mode, scan_enable, busy, done, pass}), 32'd0);
    check("rst_err", 32'({err_count, err_chain, scan_data_in}), 32'd0);
    rstp = 1'b0;

    // Fault-free alternating flush.
    setup(9'h000, 9'h000, 8, 8, 0, 0, 0, 0);
    run(0, '0, -1, r_err, r_mask);
    check("t1_err", r_err, 32'd0);

    // User transition pattern.
    setup(9'h155, 9'h0aa, 8, 8, 0, 0, 0, 0);
    run(1, 5'b01100, -1, r_err, r_mask);
    check("t2_err", r_err, 32'd0);

    // Chain 1 output stuck-at-1.
    setup(9'h000, 9'h000, 8, 8, 0, 0, 1, 1);
    run(0, '0, -1, r_err, r_mask);
    check("t3_err", r_err, 32'd4);
    check("t3_mask", r_mask, 32'b10);
`ifdef SCAN_CHK_FAIL_CAPTURE_EN
    check("t6_vld", 32'(ff_vld), 32'd1);
    check("t6_idx", 32'(ff_idx), 32'd1);
    check("t6_chain", 32'(ff_chain), 32'd1);
`endif

    // Both chains one flop too long: every compare in the window is off by one bit.
    setup(9'h001, 9'h000, 9, 9, 0, 0, 0, 0);
    run(0, '0, -1, r_err, r_mask);
    check("t4_err", r_err, 32'd16);
    check("t4_mask", r_mask, 32'b11);

    // Unknown on chain 0 output counts as a mismatch on every compare.
    setup(9'h000, 9'h000, 8, 8, 0, 0, 0, 0);
    x_en[0] = 1'b1;
    run(3, '0, -1, r_err, r_mask);
    check("x_err", r_err, 32'd8);
    check("x_mask", r_mask, 32'b01);
    x_en[0] = 1'b0;

    // Reset at c=5 aborts; start together with reset is ignored.
    setup(9'h000, 9'h000, 8, 8, 0, 0, 1, 1);
    mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rstp = 1'b1;
    @(negedge clk);
    check("abort_ctrl", 32'({test_mode, scan_enable, busy, done, pass}), 32'd0);
    check("abort_err", 32'({err_count, err_chain, scan_data_in}), 32'd0);
    start = 1'b1;
    @(negedge clk);
    rstp = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_ign", 32'(busy), 32'd0);

    // Start pulsed mid-SHIFT must not restart or lengthen the run.
    setup(9'h000, 9'h000, 8, 8, 0, 0, 0, 0);
    run(0, '0, 6, r_err, r_mask);
    check("t5_err", r_err, 32'd0);

    // Randomized runs.
    for (int t = 0; t < 24; t++) begin
      int m;
      logic [PW-1:0] p;
      m = int'($urandom_range(0, 3));
      p = PW'($urandom);
      setup(9'($urandom), 9'($urandom),
            ($urandom_range(0, 3) == 0) ? 9 : 8, ($urandom_range(0, 3) == 0) ? 9 : 8,
            ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
      run(m, p, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1, r_err, r_mask);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
